// File: rtl/camera_scroll_ctrl.sv
// Camera sequencer: watches the character's absolute y, smoothly scrolls the
// view base one block at a time, commits camera_y, then settles before re-arming.
module camera_scroll_ctrl #(
  parameter int PHY_WIDTH    = 16,
  parameter int BLOCK_WIDTH  = 480,
  parameter int CAM_WIDTH    = 5,
  parameter int MAX_BLOCK    = 31,
  parameter int HYST         = 8,
  parameter int SCROLL_STEP  = 16,
  parameter int SETTLE_TICKS = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 tick,
  input  logic                 freeze,
  input  logic [PHY_WIDTH-1:0] char_abs_y,
  output logic [CAM_WIDTH-1:0] camera_y,
  output logic [PHY_WIDTH-1:0] view_base_y,
  output logic                 busy,
  output logic                 block_switch,
  output logic                 switch_up
);

  localparam int W1    = PHY_WIDTH + 1;
  localparam int CNT_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

  localparam logic [W1-1:0]        LP_BW       = W1'(BLOCK_WIDTH);
  localparam logic [W1-1:0]        LP_HYST     = W1'(HYST);
  localparam logic [W1-1:0]        LP_STEP     = W1'(SCROLL_STEP);
  localparam logic [CAM_WIDTH-1:0] LP_CAM_MAX  = CAM_WIDTH'(MAX_BLOCK);
  localparam logic [CAM_WIDTH-1:0] LP_CAM_ONE  = CAM_WIDTH'(1);
  localparam logic [CNT_W-1:0]     LP_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     LP_CNT_LAST = CNT_W'(SETTLE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL_UP,
    ST_SCROLL_DOWN,
    ST_SETTLE
  } state_t;

  state_t               r_state;
  logic [CAM_WIDTH-1:0] r_cam;
  logic [PHY_WIDTH-1:0] r_base;
  logic [PHY_WIDTH-1:0] r_target;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_switch;
  logic                 r_up;

  logic [W1-1:0] w_lo;
  logic [W1-1:0] w_hi;
  logic [W1-1:0] w_y;
  logic [W1-1:0] w_base;
  logic [W1-1:0] w_tgt;
  logic [W1-1:0] w_up_next;
  logic [W1-1:0] w_dn_next;
  logic [W1-1:0] w_dn_tgt;
  logic          w_up_done;
  logic          w_dn_done;
  logic          w_go_up;
  logic          w_go_dn;

  always_comb begin
    w_lo      = LP_BW * W1'(r_cam);
    w_hi      = w_lo + LP_BW;
    w_dn_tgt  = w_lo - LP_BW;
    w_y       = W1'(char_abs_y);
    w_base    = W1'(r_base);
    w_tgt     = W1'(r_target);
    w_up_next = w_base + LP_STEP;
    w_dn_next = w_base - LP_STEP;
    w_up_done = (w_up_next >= w_tgt);
    // Down-step completion compared on the target side so it never underflows.
    w_dn_done = (w_base <= w_tgt + LP_STEP);
    w_go_up   = (w_y >= w_hi + LP_HYST) && (r_cam < LP_CAM_MAX);
    w_go_dn   = (r_cam != '0) && (w_y + LP_HYST < w_lo);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= ST_IDLE;
      r_cam    <= '0;
      r_base   <= '0;
      r_target <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_switch <= 1'b0;
      r_up     <= 1'b0;
    end else if (freeze) begin
      r_switch <= 1'b0;
    end else begin
      r_switch <= 1'b0;
      if (tick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_go_up) begin
              r_state  <= ST_SCROLL_UP;
              r_target <= w_hi[PHY_WIDTH-1:0];
              r_busy   <= 1'b1;
            end else if (w_go_dn) begin
              r_state  <= ST_SCROLL_DOWN;
              r_target <= w_dn_tgt[PHY_WIDTH-1:0];
              r_busy   <= 1'b1;
            end
          end
          ST_SCROLL_UP: begin
            if (w_up_done) begin
              r_base   <= r_target;
              r_cam    <= r_cam + LP_CAM_ONE;
              r_switch <= 1'b1;
              r_up     <= 1'b1;
              r_cnt    <= '0;
              r_state  <= ST_SETTLE;
            end else begin
              r_base <= w_up_next[PHY_WIDTH-1:0];
            end
          end
          ST_SCROLL_DOWN: begin
            if (w_dn_done) begin
              r_base   <= r_target;
              r_cam    <= r_cam - LP_CAM_ONE;
              r_switch <= 1'b1;
              r_up     <= 1'b0;
              r_cnt    <= '0;
              r_state  <= ST_SETTLE;
            end else begin
              r_base <= w_dn_next[PHY_WIDTH-1:0];
            end
          end
          ST_SETTLE: begin
            if (r_cnt == LP_CNT_LAST) begin
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + LP_CNT_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign camera_y     = r_cam;
  assign view_base_y  = r_base;
  assign busy         = r_busy;
  assign block_switch = r_switch;
  assign switch_up    = r_up;

endmodule

// File: tb/tb_camera_scroll_ctrl.sv
// Bench for camera_scroll_ctrl: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a tick-level reference model.
module tb_camera_scroll_ctrl;

  localparam int BW     = 480;
  localparam int HYST   = 8;
  localparam int STEP   = 16;
  localparam int SETTLE = 4;
  localparam int MAXB   = 31;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tick    = 1'b0;
  logic        freeze  = 1'b0;
  logic [15:0] char_abs_y = '0;

  logic [4:0]  camera_y;
  logic [15:0] view_base_y;
  logic        busy, block_switch, switch_up;

  logic [4:0]  camera_y2;
  logic [15:0] view_base_y2;
  logic        busy2, block_switch2, switch_up2;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  int m_cam, m_base, m_tgt, m_dir, m_settle, m_sw, m_up;

  always #5 sys_clk = ~sys_clk;

  camera_scroll_ctrl u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .freeze(freeze),
    .char_abs_y(char_abs_y), .camera_y(camera_y), .view_base_y(view_base_y),
    .busy(busy), .block_switch(block_switch), .switch_up(switch_up)
  );

  camera_scroll_ctrl #(.SCROLL_STEP(100)) u_dut100 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick(tick), .freeze(freeze),
    .char_abs_y(char_abs_y), .camera_y(camera_y2), .view_base_y(view_base_y2),
    .busy(busy2), .block_switch(block_switch2), .switch_up(switch_up2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit frz, input bit tk, input int y);
    if (rst) begin
      m_cam = 0; m_base = 0; m_tgt = 0; m_dir = 0; m_settle = 0; m_sw = 0; m_up = 0;
      return;
    end
    m_sw = 0;
    if (frz || !tk) return;
    if (m_dir > 0) begin
      m_base = (m_base + STEP > m_tgt) ? m_tgt : m_base + STEP;
    end else if (m_dir < 0) begin
      m_base = (m_base - STEP < m_tgt) ? m_tgt : m_base - STEP;
    end else if (m_settle > 0) begin
      m_settle--;
    end else begin
      if (y >= (m_cam + 1) * BW + HYST && m_cam < MAXB) begin
        m_dir = 1; m_tgt = (m_cam + 1) * BW;
      end else if (m_cam > 0 && y < m_cam * BW - HYST) begin
        m_dir = -1; m_tgt = (m_cam - 1) * BW;
      end
      return;
    end
    if (m_dir != 0 && m_base == m_tgt) begin
      m_cam    = m_cam + m_dir;
      m_up     = (m_dir > 0) ? 1 : 0;
      m_sw     = 1;
      m_dir    = 0;
      m_settle = SETTLE;
    end
  endtask

  task automatic compare_all();
    check("camera_y", int'(camera_y), m_cam);
    check("view_base_y", int'(view_base_y), m_base);
    check("busy", int'(busy), (m_dir != 0 || m_settle > 0) ? 1 : 0);
    check("block_switch", int'(block_switch), m_sw);
    check("switch_up", int'(switch_up), m_up);
  endtask

  task automatic cyc(input bit rst, input bit frz, input bit tk, input int y);
    sys_rst = rst; freeze = frz; tick = tk; char_abs_y = 16'(y);
    @(posedge sys_clk);
    model_step(rst, frz, tk, y);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int pulses;
    int y;
    int bases [5];
    bases = '{100, 200, 300, 400, 480};

    // reset mid-scroll at base 240
    do_reset(2);
    cyc(0, 0, 1, 488);
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, 488);
    check("pre_reset_base", int'(view_base_y), 240);
    do_reset(3);
    check("rst_cam", int'(camera_y), 0);
    check("rst_base", int'(view_base_y), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_switch", int'(block_switch), 0);
    cyc(0, 0, 1, 0);
    check("rst_idle_stays", int'(busy), 0);

    // basic upward scroll and settle
    do_reset(1);
    cyc(0, 0, 1, 488);
    check("up_eval_no_move", int'(view_base_y), 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 488);
    check("up_base", int'(view_base_y), 480);
    check("up_cam", int'(camera_y), 1);
    check("up_pulse", int'(block_switch), 1);
    check("up_dir", int'(switch_up), 1);
    cyc(0, 0, 0, 488);
    check("up_pulse_once", int'(block_switch), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 488);
    check("settle_busy", int'(busy), 1);
    cyc(0, 0, 1, 488);
    check("settle_done", int'(busy), 0);

    // hysteresis both ways, then downward scroll
    do_reset(1);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 487);
    check("hyst_up_cam", int'(camera_y), 0);
    check("hyst_up_busy", int'(busy), 0);
    for (int i = 0; i < 35; i++) cyc(0, 0, 1, 488);
    check("to_block1", int'(camera_y), 1);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 472);
    check("hyst_dn_cam", int'(camera_y), 1);
    check("hyst_dn_busy", int'(busy), 0);
    cyc(0, 0, 1, 471);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1, 471);
    check("dn_base", int'(view_base_y), 0);
    check("dn_cam", int'(camera_y), 0);
    check("dn_dir", int'(switch_up), 0);
    check("dn_pulse", int'(block_switch), 1);

    // large step instance: clamped final step
    do_reset(2);
    cyc(0, 0, 1, 500);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 500);
      check("step100_base", int'(view_base_y2), bases[i]);
      check("step100_pulse", int'(block_switch2), (i == 4) ? 1 : 0);
    end
    check("step100_cam", int'(camera_y2), 1);

    // freeze mid-scroll
    do_reset(1);
    cyc(0, 0, 1, 488);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 488);
    check("frz_pre", int'(view_base_y), 160);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 488);
    check("frz_hold", int'(view_base_y), 160);
    check("frz_busy", int'(busy), 1);
    for (int i = 0; i < 19; i++) cyc(0, 0, 1, 488);
    check("frz_no_early", int'(camera_y), 0);
    cyc(0, 0, 1, 488);
    check("frz_commit_cam", int'(camera_y), 1);
    check("frz_commit_pulse", int'(block_switch), 1);

    // multi-block climb, one block per scroll
    do_reset(1);
    pulses = 0;
    for (int i = 0; i < 300 && !(camera_y == 5'd3 && !busy); i++) begin
      cyc(0, 0, 1, 1500);
      pulses += int'(block_switch);
    end
    check("multi_cam", int'(camera_y), 3);
    check("multi_pulses", pulses, 3);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 1500);
    check("multi_stay", int'(camera_y), 3);

    // top block cannot switch higher
    for (int i = 0; i < 1200 && !(camera_y == 5'd31 && !busy); i++) cyc(0, 0, 1, 15368);
    check("top_cam", int'(camera_y), 31);
    for (int i = 0; i < 50; i++) cyc(0, 0, 1, 15368);
    check("top_hold_cam", int'(camera_y), 31);
    check("top_hold_busy", int'(busy), 0);
    check("top_base", int'(view_base_y), 31 * BW);

    // randomized traffic around block boundaries
    do_reset(1);
    y = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0)
          y = int'($urandom_range(0, 3000));
        else
          y = int'($urandom_range(1, 6)) * BW + int'($urandom_range(0, 24)) - 12;
      end
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 2) != 0), y);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
